arrow_banner_renderer: RTL and testbench

- Consumes the 1440-bit glyph-row pixel map (12 rows x 120 columns, MSB = top-left) produced by the arrow/banner generator.
- Rasterises it onto the VGA frame at a fixed origin with integer scaling.
- Latches the map once per frame so the image never tears.
- Runs a per-frame highlight/blink state machine triggered by the UP key; its output feeds the colour mapper.

---
 rtl/arrow_banner_renderer.sv | 141 ++++++++++++++
 tb/tb_arrow_banner_renderer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_banner_renderer.sv
// arrow_banner_renderer: per-frame latched 12x120 glyph map rasterised at
// (X0,Y0) with 2^SCALE_LOG2 scaling, plus an UP-key highlight/blink FSM.
module arrow_banner_renderer #(
  parameter int X0            = 200,
  parameter int Y0            = 100,
  parameter int SCALE_LOG2    = 1,
  parameter int HILITE_FRAMES = 120,
  parameter int BLINK_FRAMES  = 15
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [1439:0] pixel_map,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          VS,
  input  logic          UP,
  output logic          pixel_on,
  output logic          in_region,
  output logic          hilite
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_HILITE = 1'b1;

  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + (120 << SCALE_LOG2));
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + (12 << SCALE_LOG2));

  localparam logic [7:0] H_LOAD = 8'(HILITE_FRAMES);
  localparam logic [5:0] B_LOAD = 6'(BLINK_FRAMES);

  logic          vs_q;
  logic          frame_tick;
  logic          up_s1;
  logic          up_s2;
  logic          up_s3;
  logic          up_pulse;
  logic          pending;
  logic [1439:0] snap;
  logic [0:0]    state;
  logic [7:0]    hcnt;
  logic [5:0]    bcnt;
  logic          phase;

  logic [10:0]   x11;
  logic [10:0]   y11;
  logic [10:0]   dx;
  logic [10:0]   dy;
  logic [6:0]    col;
  logic [3:0]    row;
  logic [10:0]   idx;
  logic [10:0]   sel;
  logic          in_box;
  logic          bit_on;
  logic          blink_off;

  assign frame_tick = vs_q & ~VS;
  assign up_pulse   = up_s2 & ~up_s3;

  // 11-bit sums keep the right/bottom edge from wrapping
  assign x11    = {1'b0, DrawX};
  assign y11    = {1'b0, DrawY};
  assign in_box = (x11 >= X_LO) && (x11 < X_HI) &&
                  (y11 >= Y_LO) && (y11 < Y_HI);

  assign dx  = x11 - X_LO;
  assign dy  = y11 - Y_LO;
  assign col = 7'(dx >> SCALE_LOG2);
  assign row = 4'(dy >> SCALE_LOG2);
  assign idx = 11'd1439 - (11'(row) * 11'd120 + 11'(col));
  assign sel = in_box ? idx : 11'd0;

  assign bit_on    = in_box & snap[sel];
  assign blink_off = (state == S_HILITE) & ~phase;
  assign hilite    = (state == S_HILITE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_q      <= 1'b0;
      up_s1     <= 1'b0;
      up_s2     <= 1'b0;
      up_s3     <= 1'b0;
      pending   <= 1'b0;
      snap      <= '0;
      in_region <= 1'b0;
      pixel_on  <= 1'b0;
    end else begin
      vs_q      <= VS;
      up_s1     <= UP;
      up_s2     <= up_s1;
      up_s3     <= up_s2;
      // a pulse coinciding with the tick survives to the next tick
      pending   <= up_pulse | (pending & ~frame_tick);
      in_region <= in_box;
      pixel_on  <= bit_on & ~blink_off;
      if (frame_tick)
        snap <= pixel_map;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
      hcnt  <= '0;
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (frame_tick) begin
      unique case (state)
        S_IDLE: begin
          if (pending) begin
            state <= S_HILITE;
            hcnt  <= H_LOAD;
            bcnt  <= B_LOAD;
            phase <= 1'b1;
          end
        end
        S_HILITE: begin
          if (pending) begin
            hcnt  <= H_LOAD;
            bcnt  <= B_LOAD;
            phase <= 1'b1;
          end else if (hcnt == 8'd1) begin
            state <= S_IDLE;
            hcnt  <= '0;
            phase <= 1'b0;
          end else begin
            hcnt <= hcnt - 8'd1;
            if (bcnt == 6'd1) begin
              bcnt  <= B_LOAD;
              phase <= ~phase;
            end else begin
              bcnt <= bcnt - 6'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arrow_banner_renderer.sv
// tb_arrow_banner_renderer: randomized scans and key presses checked against
// a frame-level behavioural model of the banner renderer.
module tb_arrow_banner_renderer;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [1439:0] pixel_map = '0;
  logic [9:0]    DrawX = '0;
  logic [9:0]    DrawY = '0;
  logic          VS = 1'b1;
  logic          UP = 1'b0;
  logic          pixel_on;
  logic          in_region;
  logic          hilite;

  arrow_banner_renderer dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .pixel_map (pixel_map),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .VS        (VS),
    .UP        (UP),
    .pixel_on  (pixel_on),
    .in_region (in_region),
    .hilite    (hilite)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // model: snapshot, pending key, highlight age in frames
  logic [1439:0] m_snap;
  bit m_vsq, m_pend, m_act;
  int m_e;
  bit h1, h2, h3;
  bit e_on, e_reg, e_hil, chk_en;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic bit m_in(int x, int y);
    return x >= 200 && x < 440 && y >= 100 && y < 124;
  endfunction

  function automatic bit m_pix(int x, int y);
    int col, row;
    bit vis;
    if (!m_in(x, y)) return 1'b0;
    col = (x - 200) / 2;
    row = (y - 100) / 2;
    vis = !m_act || ((m_e / 15) % 2 == 0);
    return m_snap[1439 - (row * 120 + col)] && vis;
  endfunction

  task automatic m_reset();
    m_snap = '0; m_vsq = 0; m_pend = 0; m_act = 0; m_e = 0;
    h1 = 0; h2 = 0; h3 = 0;
    e_on = 0; e_reg = 0; e_hil = 0;
  endtask

  // drive one cycle at a negedge, predict outputs after the next posedge
  task automatic step(input int x, input int y, input bit vs, input bit up);
    bit pulse, tick;
    DrawX = 10'(x); DrawY = 10'(y); VS = vs; UP = up;
    e_reg = m_in(x, y);
    e_on  = m_pix(x, y);
    pulse = h2 && !h3;
    tick  = m_vsq && !vs;
    if (tick) begin
      m_snap = pixel_map;
      if (m_pend) begin
        m_act = 1; m_e = 0;
      end else if (m_act) begin
        m_e++;
        if (m_e == 120) m_act = 0;
      end
    end
    m_pend = pulse || (m_pend && !tick);
    m_vsq = vs;
    h3 = h2; h2 = h1; h1 = up;
    e_hil = m_act;
    @(negedge Clk);
  endtask

  always @(posedge Clk) begin
    bit en, xo, xr, xh;
    en = chk_en; xo = e_on; xr = e_reg; xh = e_hil;
    #1;
    if (en && Reset_n) begin
      chk("pixel_on", pixel_on, xo);
      chk("in_region", in_region, xr);
      chk("hilite", hilite, xh);
    end
  end

  task automatic probe(input string nm, input int x, input int y,
                       input bit eon, input bit ereg);
    chk({nm, "_model"}, m_pix(x, y), eon);
    step(x, y, 1, 0);
    chk({nm, "_on"}, pixel_on, eon);
    chk({nm, "_reg"}, in_region, ereg);
  endtask

  task automatic rscan(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
      end else begin
        x = $urandom_range(190, 445); y = $urandom_range(95, 130);
      end
      step(x, y, 1, 0);
    end
  endtask

  task automatic frame(input int n);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    rscan(n);
  endtask

  task automatic press();
    for (int i = 0; i < 3; i++) step(200, 100, 1, 1);
    for (int i = 0; i < 3; i++) step(200, 100, 1, 0);
  endtask

  task automatic do_reset();
    Reset_n = 0; chk_en = 0; UP = 0; VS = 1;
    m_reset();
    repeat (5) @(negedge Clk);
    chk("reset_pix", pixel_on, 1'b0);
    chk("reset_hil", hilite, 1'b0);
    Reset_n = 1; chk_en = 1;
    step(0, 0, 1, 0);
  endtask

  int hl_cnt, vis_cnt;

  initial begin
    chk_en = 0;
    m_reset();
    @(negedge Clk);
    pixel_map = '1;
    do_reset();
    probe("pre_frame", 200, 100, 0, 1);
    frame(0);
    probe("first_frame", 200, 100, 1, 1);

    pixel_map = '0; pixel_map[1439] = 1'b1;
    frame(0);
    probe("tl_a", 200, 100, 1, 1);
    probe("tl_b", 201, 101, 1, 1);
    probe("tl_c", 202, 100, 0, 1);
    probe("tl_d", 200, 102, 0, 1);
    probe("br_in", 439, 123, 0, 1);
    probe("br_out", 440, 123, 0, 0);
    probe("bot_out", 439, 124, 0, 0);
    rscan(40);

    pixel_map = '0; pixel_map[0] = 1'b1;
    frame(0);
    probe("b0_a", 438, 122, 1, 1);
    probe("b0_b", 439, 123, 1, 1);
    probe("b0_c", 437, 123, 0, 1);
    probe("b0_d", 439, 121, 0, 1);
    rscan(40);

    pixel_map = '1;
    frame(4);
    pixel_map = '0;
    probe("tear_hold", 300, 110, 1, 1);
    rscan(10);
    frame(0);
    probe("tear_new", 300, 110, 0, 1);

    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < 45; i++) pixel_map[i*32 +: 32] = $urandom();
      frame(20);
    end

    pixel_map = '1;
    frame(0);
    press();
    hl_cnt = 0; vis_cnt = 0;
    for (int f = 0; f < 130; f++) begin
      frame(1);
      step(200, 100, 1, 0);
      if (f == 0) chk("hl_entry", hilite, 1'b1);
      if (hilite) begin
        hl_cnt++;
        if (pixel_on) vis_cnt++;
      end
    end
    chk("hl_120", 1'(hl_cnt == 120), 1'b1);
    chk("blink_60", 1'(vis_cnt == 60), 1'b1);

    press();
    hl_cnt = 0;
    for (int f = 0; f < 260; f++) begin
      if (f == 100) press();
      frame(0);
      step(200, 100, 1, 0);
      if (hilite) hl_cnt++;
    end
    chk("retrig_220", 1'(hl_cnt == 220), 1'b1);

    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("collide_wait", hilite, 1'b0);
    frame(0);
    chk("collide_enter", hilite, 1'b1);

    frame(3);
    Reset_n = 0; chk_en = 0;
    #1;
    chk("async_reset", hilite, 1'b0);
    m_reset();
    repeat (3) @(negedge Clk);
    Reset_n = 1; chk_en = 1;
    step(0, 0, 1, 0);
    probe("post_reset", 200, 100, 0, 1);

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 45; i++) pixel_map[i*32 +: 32] = $urandom();
      if ($urandom_range(0, 9) == 0) press();
      frame(6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
